// File: rtl/pac_pkg.sv
// Shared direction encodings, game-phase type and grid constants for the pac-man
// movement controller.
package pac_pkg;

    localparam logic [3:0] DIR_NONE  = 4'b0000;
    localparam logic [3:0] DIR_UP    = 4'b0001;
    localparam logic [3:0] DIR_DOWN  = 4'b0010;
    localparam logic [3:0] DIR_LEFT  = 4'b0100;
    localparam logic [3:0] DIR_RIGHT = 4'b1000;

    localparam int GRID_MAX_DEF = 4;
    // Row stride of the wall bitmap (bit index y*5+x) and its total size.
    localparam int MAP_STRIDE   = 5;
    localparam int MAP_CELLS    = 25;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    function automatic logic [3:0] dir_reverse(input logic [3:0] dir);
        logic [3:0] rev;
        rev = DIR_NONE;
        case (dir)
            DIR_UP:    rev = DIR_DOWN;
            DIR_DOWN:  rev = DIR_UP;
            DIR_LEFT:  rev = DIR_RIGHT;
            DIR_RIGHT: rev = DIR_LEFT;
            default:   rev = DIR_NONE;
        endcase
        return rev;
    endfunction

    function automatic logic is_onehot4(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/pac_tick_gen.sv
// Step-tick divider: counts enabled cycles and pulses o_tick for one cycle on the
// last count of every TICK_DIV-cycle interval.
module pac_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign o_tick = i_en && (cnt_q == CNT_LAST);

    // Clear wins over enable; a disabled counter simply holds its value.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = o_tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pac_move_ctrl.sv
// Pac-man movement sequencer: game-phase FSM, turn buffer, wall/edge legality and
// one-hot move issue per step tick. Optional auto-turn search: PAC_AUTO_TURN_EN.
module pac_move_ctrl
    import pac_pkg::*;
#(
    parameter int          TICK_DIV = 25_000_000,
    parameter int          GRID_MAX = GRID_MAX_DEF,
    parameter logic [24:0] WALL_MAP = 25'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_pause,
    input  logic [3:0] i_key,
    input  logic       i_hit,
    input  logic [2:0] i_pos_x,
    input  logic [2:0] i_pos_y,
    output logic [3:0] o_command,
    output logic [1:0] o_state,
    output logic [3:0] o_dir,
    output logic [7:0] o_steps
);

    game_state_t state_q, state_d;
    logic [3:0]  cmd_q, cmd_d;
    logic [3:0]  dir_q, dir_d;
    logic [3:0]  buf_q, buf_d;
    logic [7:0]  steps_q, steps_d;

    logic        tick;
    logic        tick_en;
    logic        tick_clr;
    logic        clr_game;
    logic        on_grid;
    logic [3:0]  ok_vec;
    logic [3:0]  auto_dir;
    int          px;
    int          py;

    // Out-of-map cells read as walls so no index ever leaves the bitmap.
    function automatic logic wall_at(input int x, input int y);
        int idx;
        idx = y * MAP_STRIDE + x;
        if (idx < 0 || idx >= MAP_CELLS) begin
            return 1'b1;
        end
        return WALL_MAP[idx[4:0]];
    endfunction

    function automatic logic dir_legal(input logic [3:0] dir, input logic [3:0] ok);
        return (dir != DIR_NONE) && ((dir & ok) == dir);
    endfunction

    // The counter only runs while the game stays in RUN across the edge, so a pause
    // or hit landing on the tick cycle freezes it and no command is issued.
    assign tick_en  = (state_q == RUN) && (state_d == RUN);
    assign tick_clr = (state_d == IDLE) || (state_d == OVER);

    pac_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_en   (tick_en),
        .i_clr  (tick_clr),
        .o_tick (tick)
    );

    // Bounds are tested before the neighbour coordinate is formed, so no 3-bit wrap.
    always_comb begin
        px      = int'(i_pos_x);
        py      = int'(i_pos_y);
        on_grid = (px <= GRID_MAX) && (py <= GRID_MAX);
        ok_vec  = DIR_NONE;
        ok_vec[0] = on_grid && (py > 0)        && !wall_at(px, py - 1);
        ok_vec[1] = on_grid && (py < GRID_MAX) && !wall_at(px, py + 1);
        ok_vec[2] = on_grid && (px > 0)        && !wall_at(px - 1, py);
        ok_vec[3] = on_grid && (px < GRID_MAX) && !wall_at(px + 1, py);
    end

`ifdef PAC_AUTO_TURN_EN
    logic [3:0] auto_cand;

    // Search order up, right, down, left; never reverse the current heading.
    always_comb begin
        auto_cand = ok_vec & ~dir_reverse(dir_q);
        auto_dir  = DIR_NONE;
        if (auto_cand[0]) begin
            auto_dir = DIR_UP;
        end else if (auto_cand[3]) begin
            auto_dir = DIR_RIGHT;
        end else if (auto_cand[1]) begin
            auto_dir = DIR_DOWN;
        end else if (auto_cand[2]) begin
            auto_dir = DIR_LEFT;
        end
    end
`else
    assign auto_dir = DIR_NONE;
`endif

    always_comb begin
        state_d = state_q;
        cmd_d   = DIR_NONE;
        dir_d   = dir_q;
        buf_d   = buf_q;
        steps_d = steps_q;

        case (state_q)
            IDLE:    if (i_start) state_d = RUN;
            RUN:     if (i_hit) state_d = OVER; else if (i_pause) state_d = PAUSE;
            PAUSE:   if (i_hit) state_d = OVER; else if (i_pause) state_d = RUN;
            OVER:    if (i_start) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        clr_game = i_start && ((state_q == IDLE) || (state_q == OVER));
        if (clr_game) begin
            dir_d   = DIR_NONE;
            buf_d   = DIR_NONE;
            steps_d = 8'd0;
        end

        if (tick) begin
            if (dir_legal(buf_q, ok_vec)) begin
                dir_d = buf_q;
                cmd_d = buf_q;
                buf_d = DIR_NONE;
            end else if (dir_legal(dir_q, ok_vec)) begin
                cmd_d = dir_q;
            end else if (auto_dir != DIR_NONE) begin
                dir_d = auto_dir;
                cmd_d = auto_dir;
            end
        end

        if (cmd_d != DIR_NONE && steps_q != 8'hFF) begin
            steps_d = steps_q + 8'd1;
        end

        // A key on the tick cycle lands here, after the tick already used the old buffer.
        if (is_onehot4(i_key) && state_q != OVER) begin
            buf_d = i_key;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= IDLE;
            cmd_q   <= DIR_NONE;
            dir_q   <= DIR_NONE;
            buf_q   <= DIR_NONE;
            steps_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            dir_q   <= dir_d;
            buf_q   <= buf_d;
            steps_q <= steps_d;
        end
    end

    assign o_command = cmd_q;
    assign o_state   = state_q;
    assign o_dir     = dir_q;
    assign o_steps   = steps_q;

endmodule
